rom_dl_ctrl: RTL and testbench

ROM download front end that sits between the HPS ioctl byte stream and the SDRAM controller's write ports. It captures download bytes and buffers them in a small FIFO. It issues toggle-handshake write requests to SDRAM port1 (every ROM byte) and port2 (sprite region only, rebased), and throttles the HPS with `ioctl_wait`. It also latches the core-mode byte and DIP switch bytes, and generates the core reset and `rom_loaded` flags.

---
 rtl/rom_dl_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rom_dl_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: HPS ioctl download front end feeding the SDRAM toggle-handshake write ports.
// Ports:
//   clk_sys, reset_n              system clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout  HPS download byte stream in
//   ioctl_wait                    backpressure to the HPS
//   port1_req/ack/a/ds/d          SDRAM write port for every ROM byte
//   port2_req/ack/a/ds/d          SDRAM write port for the sprite region, rebased to SP_BASE
//   port_we                       SDRAM write window
//   core_mod, sw0, sw1            latched core-mode and DIP switch bytes
//   rom_loaded, core_reset        ROM commit flag and game-logic reset
module rom_dl_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = 25'h30000,
    parameter logic [15:0] RST_CYCLES = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic [7:0]  core_mod,
    output logic [7:0]  sw0,
    output logic [7:0]  sw1,
    output logic        rom_loaded,
    output logic        core_reset
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIWM = CW'(FIFO_DEPTH - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nx;
    logic          r_wr_d;
    logic          r_cap_v;
    logic [24:0]   r_cap_addr;
    logic [7:0]    r_cap_data;
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_p2_issued;
    logic          r_dl_seen;
    logic [15:0]   r_rst_cnt;
    logic          w_rise, w_rom_dl, w_full, w_empty, w_push, w_pop, w_done, w_rl_set;
    logic [32:0]   w_head;
    logic [24:0]   w_head_addr;
    logic [7:0]    w_head_data;
    logic          w_head_p2;
    logic [23:0]   w_p2_off;
    logic          w_unused;

    assign w_rise      = ioctl_wr & ~r_wr_d;
    assign w_rom_dl    = ioctl_download & (ioctl_index == 8'd0);
    assign w_full      = r_count == FULL;
    assign w_empty     = r_count == '0;
    assign w_push      = r_cap_v & ~w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[32:8];
    assign w_head_data = w_head[7:0];
    assign w_head_p2   = w_head_addr >= SP_BASE;
    // Bit 24 of the offset never reaches the 23-bit word address, so drop it early.
    assign w_p2_off    = w_head_addr[23:0] - SP_BASE[23:0];
    assign port_we     = w_rom_dl | ~w_empty;
    // The overflow flag is a debug observable with no functional consumer.
    assign w_unused    = &{1'b0, r_ovf};
    // The capture stage must also be empty, else a byte still in flight could be missed.
    assign w_rl_set    = r_dl_seen & ~ioctl_download & w_empty & ~r_cap_v & (r_state == S_IDLE);

    // Strobe edge detect plus one capture stage in front of the FIFO.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_d     <= 1'b0;
            r_cap_v    <= 1'b0;
            r_cap_addr <= '0;
            r_cap_data <= '0;
        end else begin
            r_wr_d  <= ioctl_wr;
            r_cap_v <= w_rise & w_rom_dl;
            if (w_rise) begin
                r_cap_addr <= ioctl_addr;
                r_cap_data <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_mod <= '0;
            sw0      <= '0;
            sw1      <= '0;
        end else if (w_rise) begin
            if (ioctl_index == 8'd1)
                core_mod <= ioctl_dout;
            // Only switch bytes 0 and 1 are wired out; bytes 2..7 are accepted and dropped.
            if (ioctl_index == 8'd254 && ioctl_addr[24:1] == '0) begin
                if (ioctl_addr[0])
                    sw1 <= ioctl_dout;
                else
                    sw0 <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {r_cap_addr, r_cap_data};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_push);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_ovf      <= r_ovf | (r_cap_v & w_full);
            // Raising at DEPTH-1 keeps one slot free for a strobe already in flight.
            ioctl_wait <= r_count >= HIWM;
        end
    end

    always_comb begin
        w_done     = (port1_ack == port1_req) && (!r_p2_issued || port2_ack == port2_req);
        w_pop      = (r_state == S_IDLE) && !w_empty;
        w_state_nx = w_pop ? S_WAIT : (r_state == S_WAIT && w_done) ? S_IDLE : r_state;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port1_req   <= 1'b0;
            port1_a     <= '0;
            port1_ds    <= '0;
            port1_d     <= '0;
            port2_req   <= 1'b0;
            port2_a     <= '0;
            port2_ds    <= '0;
            port2_d     <= '0;
            r_p2_issued <= 1'b0;
        end else if (w_pop) begin
            port1_req   <= ~port1_req;
            port1_a     <= w_head_addr[23:1];
            port1_ds    <= {w_head_addr[0], ~w_head_addr[0]};
            port1_d     <= {2{w_head_data}};
            r_p2_issued <= w_head_p2;
            if (w_head_p2) begin
                port2_req <= ~port2_req;
                port2_a   <= w_p2_off[23:1];
                port2_ds  <= {w_p2_off[0], ~w_p2_off[0]};
                port2_d   <= {2{w_head_data}};
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_seen  <= 1'b0;
            rom_loaded <= 1'b0;
            r_rst_cnt  <= RST_CYCLES;
            core_reset <= 1'b1;
        end else begin
            r_dl_seen  <= r_dl_seen | w_rom_dl;
            rom_loaded <= w_rom_dl ? 1'b0 : w_rl_set ? 1'b1 : rom_loaded;
            r_rst_cnt  <= (!rom_loaded || w_rom_dl) ? RST_CYCLES :
                          (r_rst_cnt != '0) ? r_rst_cnt - 16'd1 : r_rst_cnt;
            core_reset <= r_rst_cnt != '0;
        end
    end
endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb_rom_dl_ctrl: scoreboard bench for rom_dl_ctrl with randomized HPS traffic and ack delays.
module tb_rom_dl_ctrl;
    localparam logic [24:0] SPB  = 25'h30000;
    localparam logic [15:0] RSTC = 16'd16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        port1_req, port2_req;
    logic        port1_ack = 1'b0;
    logic        port2_ack = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, rom_loaded, core_reset;
    logic [7:0]  core_mod, sw0, sw1;

    rom_dl_ctrl #(.FIFO_DEPTH(4), .SP_BASE(SPB), .RST_CYCLES(RSTC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_d(port2_d),
        .port_we(port_we), .core_mod(core_mod), .sw0(sw0), .sw1(sw1),
        .rom_loaded(rom_loaded), .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [22:0] a1;
        logic [1:0]  ds1;
        logic [15:0] d;
        logic        p2;
        logic [22:0] a2;
        logic [1:0]  ds2;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tog_cyc = 0;
    int   ntog = 0;
    int   str_cyc = 0;
    int   dmin1 = 0, dmax1 = 0, dmin2 = 0, dmax2 = 0;
    bit   seen_wait = 0;

    always @(posedge clk_sys) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // SDRAM side: each port acknowledges a pending toggle after a random delay.
    initial begin
        int c1 = 0, c2 = 0, d1 = 0, d2 = 0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (!reset_n) begin
                port1_ack = 1'b0;
                port2_ack = 1'b0;
                c1 = 0;
                c2 = 0;
            end else begin
                if (port1_ack != port1_req) begin
                    if (c1 == 0) d1 = $urandom_range(dmax1, dmin1);
                    if (c1 >= d1) begin port1_ack = port1_req; c1 = 0; end
                    else c1++;
                end
                if (port2_ack != port2_req) begin
                    if (c2 == 0) d2 = $urandom_range(dmax2, dmin2);
                    if (c2 >= d2) begin port2_ack = port2_req; c2 = 0; end
                    else c2++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every port1 request toggle.
    initial begin
        logic pr1 = 0, pr2 = 0, pa1 = 0, pa2 = 0;
        logic [40:0] l1 = '0, l2 = '0;
        txn_t t;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                pr1 = 0; pr2 = 0; pa1 = 0; pa2 = 0; l1 = '0; l2 = '0;
            end else begin
                if (ioctl_wait) seen_wait = 1;
                if (port1_req != pr1) begin
                    tog_cyc = cyc;
                    ntog++;
                    chk("one_outstanding", {pa1 == pr1, pa2 == pr2}, 2'b11);
                    if (sb.size() == 0) chk("unexpected_req", sb.size(), 1);
                    else begin
                        t = sb.pop_front();
                        chk("p1_a", port1_a, t.a1);
                        chk("p1_ds", port1_ds, t.ds1);
                        chk("p1_d", port1_d, t.d);
                        chk("p2_issue", port2_req != pr2, t.p2);
                        if (t.p2) begin
                            chk("p2_a", port2_a, t.a2);
                            chk("p2_ds", port2_ds, t.ds2);
                            chk("p2_d", port2_d, t.d);
                        end
                    end
                end else begin
                    if (port2_req != pr2) chk("p2_alone", port2_req, pr2);
                    if ({port1_a, port1_ds, port1_d} != l1)
                        chk("p1_hold", {port1_a, port1_ds, port1_d}, l1);
                end
                if (port2_req == pr2 && {port2_a, port2_ds, port2_d} != l2)
                    chk("p2_hold", {port2_a, port2_ds, port2_d}, l2);
                pr1 = port1_req; pr2 = port2_req; pa1 = port1_ack; pa2 = port2_ack;
                l1 = {port1_a, port1_ds, port1_d};
                l2 = {port2_a, port2_ds, port2_d};
            end
        end
    end

    // One HPS byte write honouring ioctl_wait; ROM bytes go into the scoreboard.
    task automatic hps_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] b);
        int n = 0;
        txn_t t;
        logic [24:0] off;
        while (ioctl_wait && n < 2000) begin @(negedge clk_sys); n++; end
        if (n >= 2000) chk("wait_timeout", ioctl_wait, 0);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = b;
        ioctl_wr    = 1'b1;
        str_cyc     = cyc;
        if (idx == 8'd0 && ioctl_download) begin
            off   = a - SPB;
            t.a1  = a[23:1];
            t.ds1 = {a[0], ~a[0]};
            t.d   = {b, b};
            t.p2  = a >= SPB;
            t.a2  = off[23:1];
            t.ds2 = {off[0], ~off[0]};
            sb.push_back(t);
        end
        repeat ($urandom_range(3, 1)) @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 3000 && !(sb.size() == 0 && port1_ack == port1_req && port2_ack == port2_req)) begin
            @(negedge clk_sys);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        chk("drain_acks", {port1_ack == port1_req, port2_ack == port2_req}, 2'b11);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic set_dly(input int a, input int b, input int c, input int d);
        dmin1 = a; dmax1 = b; dmin2 = c; dmax2 = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_reqs"}, {port1_req, port2_req}, 2'b00);
        chk({tag, "_p1"}, {port1_a, port1_ds, port1_d}, 0);
        chk({tag, "_p2"}, {port2_a, port2_ds, port2_d}, 0);
        chk({tag, "_wait"}, ioctl_wait, 0);
        chk({tag, "_cfg"}, {core_mod, sw0, sw1}, 0);
        chk({tag, "_loaded"}, rom_loaded, 0);
        chk({tag, "_core_reset"}, core_reset, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s, n, rl_cyc, cr_cyc;
        logic p2b;
        logic [24:0] a;
        bit rl_prev;
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        repeat (2) @(negedge clk_sys);

        // Single byte, latency and byte-lane mapping.
        set_dly(3, 3, 3, 3);
        p2b = port2_req;
        hps_byte(8'd0, 25'h00001, 8'hA5);
        s = str_cyc;
        wait_idle();
        chk("t1_latency", tog_cyc - s, 3);
        chk("t1_p2_unchanged", port2_req, p2b);

        // Sprite region byte issues on both ports; second ack arrives late.
        set_dly(2, 2, 8, 8);
        hps_byte(8'd0, 25'h30003, 8'h3C);
        hps_byte(8'd0, 25'h00010, 8'h77);
        wait_idle();

        // Core mode and DIP switches never reach the SDRAM ports.
        set_dly(0, 0, 0, 0);
        n = ntog;
        hps_byte(8'd1, 25'h0, 8'h0B);
        hps_byte(8'd254, 25'h0, 8'h12);
        hps_byte(8'd254, 25'h1, 8'h34);
        hps_byte(8'd254, 25'h8, 8'hFF);
        hps_byte(8'd254, 25'h2, 8'h77);
        ioctl_index = 8'd0;
        repeat (4) @(negedge clk_sys);
        chk("core_mod", core_mod, 8'h0B);
        chk("sw0", sw0, 8'h12);
        chk("sw1", sw1, 8'h34);
        chk("cfg_no_req", ntog, n);

        // Slow acks force backpressure; every byte must still come out in order.
        set_dly(20, 20, 20, 20);
        seen_wait = 0;
        for (int i = 0; i < 8; i++)
            hps_byte(8'd0, (i % 2) ? SPB + 25'($urandom_range(255, 0)) : 25'($urandom_range(1023, 0)),
                     8'($urandom));
        wait_idle();
        chk("wait_seen", seen_wait, 1);
        chk("ovf_bp", dut.r_ovf, 0);

        // Random traffic including the sprite-region boundary.
        set_dly(0, 4, 0, 4);
        hps_byte(8'd0, SPB - 25'd1, 8'h81);
        hps_byte(8'd0, SPB, 8'h82);
        hps_byte(8'd0, SPB + 25'd1, 8'h83);
        hps_byte(8'd0, 25'h1FFFFFF, 8'h84);
        for (int i = 0; i < 24; i++)
            hps_byte(8'd0, 25'($urandom_range(32'h5FFFF, 0)), 8'($urandom));
        wait_idle();
        chk("ovf_rand", dut.r_ovf, 0);

        // Download end: rom_loaded after the last ack, core_reset RST_CYCLES+1 later.
        set_dly(5, 5, 5, 5);
        chk("rl_during_dl", rom_loaded, 0);
        hps_byte(8'd0, 25'h00100, 8'h11);
        hps_byte(8'd0, SPB + 25'h00101, 8'h22);
        ioctl_download = 1'b0;
        rl_prev = 0;
        rl_cyc = -1;
        cr_cyc = -1;
        for (int i = 0; i < 400 && cr_cyc < 0; i++) begin
            @(negedge clk_sys);
            if (rom_loaded && !rl_prev) begin
                rl_cyc = cyc;
                chk("rl_after_ack", {sb.size() == 0, port1_ack == port1_req, port2_ack == port2_req}, 3'b111);
            end
            if (rl_cyc < 0) chk("cr_before_rl", core_reset, 1);
            if (rl_cyc >= 0 && !core_reset) cr_cyc = cyc;
            rl_prev = rom_loaded;
        end
        chk("rl_set", rom_loaded, 1);
        chk("core_reset_delay", cr_cyc - rl_cyc, 17);

        // New download clears rom_loaded and re-asserts core_reset.
        ioctl_download = 1'b1;
        ioctl_index = 8'd0;
        @(negedge clk_sys);
        chk("rl_cleared", rom_loaded, 0);
        repeat (3) @(negedge clk_sys);
        chk("cr_reasserted", core_reset, 1);

        // Reset in the middle of a transfer with entries still queued.
        set_dly(40, 40, 40, 40);
        for (int i = 0; i < 4; i++) hps_byte(8'd0, SPB + 25'(i * 2), 8'(8'h40 + i));
        repeat (2) @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        sb.delete();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        n = ntog;
        repeat (30) @(negedge clk_sys);
        chk("post_rst_quiet", ntog, n);
        chk("post_rst_req", {port1_req, port2_req}, 2'b00);
        set_dly(1, 1, 1, 1);
        a = SPB + 25'h10;
        hps_byte(8'd0, a, 8'h5A);
        wait_idle();
        chk("post_rst_issue", ntog, n + 1);
        chk("final_ovf", dut.r_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
